// File: rtl/data_mem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready, a fixed number of
// wait states, then a held response carrying read data or a store acknowledgement plus an error flag.
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  input  logic        resp_ready
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [3:0]        count;
  logic              lat_write;
  logic              lat_err;
  logic [IDX_W-1:0]  lat_index;
  logic [31:0]       lat_wdata;
  logic [31:0]       mem [DEPTH_WORDS];

  logic [32:0]       diff;
  logic              addr_err;
  logic              accept;
  logic              commit;

  // The 33rd bit of the subtraction flags addresses below the base without any wrap-around.
  always_comb begin
    diff     = {1'b0, req_addr} - {1'b0, BASE_ADDR};
    addr_err = (diff[1:0] != 2'b00) || diff[32] || (diff[31:2] >= 30'(DEPTH_WORDS));
    accept   = req_valid && req_ready;
    commit   = (state == ST_WAIT) && (count == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (count == 4'd0) begin
          next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // The edge after acceptance always passes through WAIT, so the response lands
  // WAIT_CYCLES+1 edges after the request was taken, even with no wait states.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count      <= 4'd0;
      lat_write  <= 1'b0;
      lat_err    <= 1'b0;
      lat_index  <= '0;
      lat_wdata  <= 32'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= 32'd0;
      end
    end else begin
      if (accept) begin
        lat_write <= req_write;
        lat_err   <= addr_err;
        lat_index <= diff[IDX_W+1:2];
        lat_wdata <= req_wdata;
        count     <= 4'(WAIT_CYCLES);
      end else if ((state == ST_WAIT) && (count != 4'd0)) begin
        count <= count - 4'd1;
      end

      if (commit) begin
        resp_valid <= 1'b1;
        resp_err   <= lat_err;
        resp_rdata <= 32'd0;
        if (!lat_err) begin
          if (lat_write) begin
            mem[lat_index] <= lat_wdata;
          end else begin
            resp_rdata <= mem[lat_index];
          end
        end
      end else if ((state == ST_RESP) && resp_ready) begin
        resp_valid <= 1'b0;
        resp_err   <= 1'b0;
        resp_rdata <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised self-checking bench for data_mem_responder; a word-array model predicts
// every response, its error flag and the request-to-response latency.
module tb_data_mem_responder;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          WAITC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        resp_ready;

  int          checkCount = 0;
  int          errorCount = 0;
  logic [31:0] modelMem [DEPTH];

  always #5 clk = ~clk;

  data_mem_responder #(
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (BASE),
    .WAIT_CYCLES(WAITC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .resp_ready(resp_ready)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Address legality from first principles: word aligned, at or above the base, inside the array.
  function automatic logic modelErr(input logic [31:0] a);
    longint off;
    off = $signed({32'd0, a}) - $signed({32'd0, BASE});
    if (a % 4 != 0) return 1'b1;
    if (off < 0) return 1'b1;
    return (off / 4) >= DEPTH;
  endfunction

  task automatic clearModel();
    for (int i = 0; i < DEPTH; i++) modelMem[i] = 32'd0;
  endtask

  // Called at a negedge with the responder idle; returns at a negedge with it idle again.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input int holdCycles, input string tag);
    logic        expErr;
    logic [31:0] expData;
    int          lat;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    expErr  = modelErr(addr);
    expData = 32'd0;
    if (!expErr) begin
      if (wr) modelMem[(addr - BASE) / 4] = wdata;
      else    expData = modelMem[(addr - BASE) / 4];
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      resp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    resp_ready = 1'b0;
    checkOutput({tag, "_latency"}, 32'(lat), 32'(WAITC + 1));
    checkOutput({tag, "_rdata"}, resp_rdata, expData);
    checkOutput({tag, "_err"}, 32'(resp_err), 32'(expErr));
    for (int i = 0; i < holdCycles; i++) begin
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = BASE + 4 * $urandom_range(0, 15);
      req_wdata = $urandom;
      @(negedge clk);
      checkOutput({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
      checkOutput({tag, "_hold_rdata"}, resp_rdata, expData);
      checkOutput({tag, "_hold_err"}, 32'(resp_err), 32'(expErr));
      checkOutput({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    checkOutput({tag, "_done_valid"}, 32'(resp_valid), 32'd0);
    checkOutput({tag, "_done_rdata"}, resp_rdata, 32'd0);
    checkOutput({tag, "_done_err"}, 32'(resp_err), 32'd0);
    checkOutput({tag, "_done_ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic doReset(input int cycles);
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = BASE;
    req_wdata = $urandom;
    repeat (cycles) @(negedge clk);
    reset     = 1'b1;
    req_valid = 1'b0;
    clearModel();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] a;
    int          kind;
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    resp_ready = 1'b0;
    clearModel();

    doReset(2);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("reset_rdata", resp_rdata, 32'd0);
    checkOutput("reset_err", 32'(resp_err), 32'd0);
    applyStimulus(1'b0, BASE + 32'h10, 32'd0, 0, "reset_lw");

    applyStimulus(1'b1, BASE + 32'h8, 32'hDEAD_BEEF, 0, "sw_8");
    applyStimulus(1'b0, BASE + 32'h8, 32'd0, 0, "lw_8");

    applyStimulus(1'b0, BASE + 32'h6, 32'd0, 0, "lw_misaligned");
    applyStimulus(1'b1, BASE + 4 * DEPTH, 32'h1234_5678, 0, "sw_oor");
    applyStimulus(1'b0, BASE + 4 * (DEPTH - 1), 32'd0, 0, "lw_last");

    applyStimulus(1'b0, BASE + 32'h8, 32'd0, 5, "backpressure");

    // Reset during the wait states must abort the store and suppress its response.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = BASE;
    req_wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    req_valid = 1'b0;
    reset     = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    clearModel();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("midreset_no_resp", 32'(resp_valid), 32'd0);
    end
    applyStimulus(1'b0, BASE, 32'd0, 0, "midreset_lw");

    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0)      a = BASE + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
      else if (kind == 1) a = BASE + 4 * (DEPTH + $urandom_range(0, 1000));
      else if (kind == 2) a = 32'hFFFF_FFFC;
      else                a = BASE + 4 * $urandom_range(0, 15);
      applyStimulus(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), $sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
